game_engine_v2: RTL and testbench

GAME_ENGINE_V2 -- requirements
Module: game_engine_v2

---
 rtl/game_engine_v2_pkg.sv | 20 ++
 rtl/game_engine_v2_player_ctrl.sv | 85 ++++++++
 rtl/game_engine_v2.sv | 96 +++++++++
 tb/tb_game_engine_v2.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_engine_v2_pkg.sv
// Shared encodings for the game engine: player motion codes, jump phases
// and the menu state value.
package game_pkg;

    typedef enum logic [1:0] {
        STATIC = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        UP     = 2'd3
    } motion_t;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } phase_t;

    localparam int STATE_MENU = 0;

endpackage

// File: rtl/game_engine_v2_player_ctrl.sv
// One player: jump phase FSM with cycle counter and registered motion code.
module player_ctrl
    import game_pkg::*;
#(
    parameter int JUMP_HALF = 50000000,
    parameter int CNT_W     = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             key_jump,
    input  logic             key_left,
    input  logic             key_right,
    output logic [1:0]       motion,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] TOP_RISE = CNT_W'(JUMP_HALF);
    localparam logic [CNT_W-1:0] TOP_FALL = CNT_W'(2 * JUMP_HALF);

    phase_t           phase_q, phase_n;
    motion_t          motion_q, motion_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= GROUND;
            motion_q <= STATIC;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_n;
            motion_q <= motion_n;
            cnt_q    <= cnt_n;
        end
    end

    always_comb begin
        phase_n  = phase_q;
        motion_n = motion_q;
        cnt_n    = cnt_q;
        if (clear) begin
            phase_n  = GROUND;
            motion_n = STATIC;
            cnt_n    = '0;
        end else if (enable) begin
            case (phase_q)
                GROUND: begin
                    if (key_jump) begin
                        phase_n = RISE;
                        cnt_n   = CNT_W'(1);
                    end
                end
                RISE: begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TOP_RISE) phase_n = FALL;
                end
                FALL: begin
                    // Landing: a held jump key relaunches only on the next cycle
                    if (cnt_inc == TOP_FALL) begin
                        phase_n = GROUND;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    phase_n = GROUND;
                    cnt_n   = '0;
                end
            endcase
            if (key_left ^ key_right) motion_n = key_left ? LEFT : RIGHT;
            else if (phase_n != GROUND) motion_n = UP;
            else motion_n = STATIC;
        end
    end

    assign motion = motion_q;
    assign phase  = phase_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/game_engine_v2.sv
// Game engine top: level menu, pause control and an array of per-player
// jump/motion controllers.
module game_engine_v2
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_LEVELS  = 5,
    parameter int JUMP_HALF   = 50000000,
    parameter int CNT_W       = 27,
    localparam int LVL_W      = $clog2(NUM_LEVELS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_next,
    input  logic                         key_prev,
    input  logic                         key_enter,
    input  logic                         key_esc,
    input  logic                         key_pause,
    input  logic [NUM_PLAYERS-1:0]       key_jump,
    input  logic [NUM_PLAYERS-1:0]       key_left,
    input  logic [NUM_PLAYERS-1:0]       key_right,
    output logic [LVL_W-1:0]             state,
    output logic [LVL_W-1:0]             select_level,
    output logic                         paused,
    output logic [2*NUM_PLAYERS-1:0]     player_state,
    output logic [2*NUM_PLAYERS-1:0]     player_jump,
    output logic [CNT_W*NUM_PLAYERS-1:0] jump_cnt
);

    localparam logic [LVL_W-1:0] MENU    = LVL_W'(STATE_MENU);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS);

    logic en_select;
    logic pause_q;
    logic in_menu;
    logic pause_edge;
    logic enable;
    logic clear;

    assign in_menu    = (state == MENU);
    assign pause_edge = key_pause & ~pause_q;
    assign enable     = ~in_menu & ~paused;
    assign clear      = ~in_menu & key_esc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= MENU;
            select_level <= LVL_W'(1);
            en_select    <= 1'b1;
            paused       <= 1'b0;
            pause_q      <= 1'b0;
        end else begin
            pause_q <= key_pause;
            if (in_menu) begin
                paused <= 1'b0;
                // Each menu key acts once per press; re-arm only when all are up
                if (key_next && en_select) begin
                    if (select_level != LVL_MAX) select_level <= select_level + LVL_W'(1);
                    en_select <= 1'b0;
                end else if (key_prev && en_select) begin
                    if (select_level != LVL_W'(1)) select_level <= select_level - LVL_W'(1);
                    en_select <= 1'b0;
                end else if (key_enter && en_select) begin
                    state     <= select_level;
                    en_select <= 1'b0;
                end else if (!key_next && !key_prev && !key_enter) begin
                    en_select <= 1'b1;
                end
            end else if (key_esc) begin
                state  <= MENU;
                paused <= 1'b0;
            end else if (pause_edge) begin
                paused <= ~paused;
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : gen_player
        player_ctrl #(
            .JUMP_HALF (JUMP_HALF),
            .CNT_W     (CNT_W)
        ) u_player (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .clear     (clear),
            .key_jump  (key_jump[p]),
            .key_left  (key_left[p]),
            .key_right (key_right[p]),
            .motion    (player_state[2*p +: 2]),
            .phase     (player_jump[2*p +: 2]),
            .cnt       (jump_cnt[CNT_W*p +: CNT_W])
        );
    end

endmodule

// File: tb/tb_game_engine_v2.sv
// Directed bench for game_engine_v2 with NUM_PLAYERS=2, NUM_LEVELS=5, JUMP_HALF=4.
module tb_game_engine_v2;

    localparam int NP    = 2;
    localparam int NL    = 5;
    localparam int JH    = 4;
    localparam int CW    = 4;
    localparam int LVL_W = $clog2(NL + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            key_next, key_prev, key_enter, key_esc, key_pause;
    logic [NP-1:0]   key_jump, key_left, key_right;
    logic [LVL_W-1:0] state, select_level;
    logic            paused;
    logic [2*NP-1:0] player_state, player_jump;
    logic [CW*NP-1:0] jump_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_engine_v2 #(
        .NUM_PLAYERS (NP),
        .NUM_LEVELS  (NL),
        .JUMP_HALF   (JH),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_next     (key_next),
        .key_prev     (key_prev),
        .key_enter    (key_enter),
        .key_esc      (key_esc),
        .key_pause    (key_pause),
        .key_jump     (key_jump),
        .key_left     (key_left),
        .key_right    (key_right),
        .state        (state),
        .select_level (select_level),
        .paused       (paused),
        .player_state (player_state),
        .player_jump  (player_jump),
        .jump_cnt     (jump_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for checks and new inputs
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] ph(input int p);
        return 32'(player_jump[2*p +: 2]);
    endfunction

    function automatic logic [31:0] mo(input int p);
        return 32'(player_state[2*p +: 2]);
    endfunction

    function automatic logic [31:0] cn(input int p);
        return 32'(jump_cnt[CW*p +: CW]);
    endfunction

    initial begin
        rst = 1'b1;
        {key_next, key_prev, key_enter, key_esc, key_pause} = '0;
        key_jump = '0; key_left = '0; key_right = '0;
        step(); step();
        chk("rst_state", 32'(state), 0);
        chk("rst_sel", 32'(select_level), 1);
        chk("rst_paused", 32'(paused), 0);
        chk("rst_pstate", 32'(player_state), 0);
        chk("rst_pjump", 32'(player_jump), 0);
        chk("rst_cnt", 32'(jump_cnt), 0);
        rst = 1'b0;
        step();

        // Held next increments once; further pulses saturate at NL
        key_next = 1'b1;
        step(); chk("next_first", 32'(select_level), 2);
        step(); step(); chk("next_held", 32'(select_level), 2);
        key_next = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            key_next = 1'b1; step();
            key_next = 1'b0; step();
            chk("next_pulse", 32'(select_level), (i + 3 > NL) ? NL : i + 3);
        end
        repeat (2) begin
            key_prev = 1'b1; step();
            key_prev = 1'b0; step();
        end
        chk("prev_to3", 32'(select_level), 3);

        key_enter = 1'b1; step();
        chk("enter_state", 32'(state), 3);
        key_enter = 1'b0; step();
        key_esc = 1'b1; step();
        chk("esc_state", 32'(state), 0);
        chk("esc_sel", 32'(select_level), 3);
        key_esc = 1'b0; step();

        key_pause = 1'b1; step();
        chk("menu_pause", 32'(paused), 0);
        key_pause = 1'b0; step();

        key_next = 1'b1; key_prev = 1'b1; step();
        chk("next_over_prev", 32'(select_level), 4);
        key_next = 1'b0; key_prev = 1'b0; step();
        key_enter = 1'b1; step();
        chk("enter_lvl4", 32'(state), 4);
        key_enter = 1'b0; step();

        // Single jump pulse on player 0: RISE 1..3, FALL 4..7, land at 8
        key_jump = 2'b01; step();
        chk("j0_phase1", ph(0), 1);
        chk("j0_cnt1", cn(0), 1);
        chk("j0_motion_up", mo(0), 3);
        key_jump = 2'b00;
        for (int c = 2; c < 2 * JH; c++) begin
            step();
            chk("j0_cnt", cn(0), 32'(c));
            chk("j0_phase", ph(0), (c < JH) ? 1 : 2);
            chk("j1_ground", ph(1), 0);
        end
        step();
        chk("j0_land_phase", ph(0), 0);
        chk("j0_land_cnt", cn(0), 0);
        chk("j0_land_motion", mo(0), 0);

        // Held jump: no double jump, relaunch right after landing
        key_jump = 2'b01; step();
        repeat (2 * JH - 2) step();
        chk("hold_cnt7", cn(0), 7);
        step();
        chk("hold_land", ph(0), 0);
        step();
        chk("hold_relaunch", ph(0), 1);
        chk("hold_relaunch_cnt", cn(0), 1);
        key_jump = 2'b00;
        repeat (2 * JH - 1) step();
        chk("hold_land2", ph(0), 0);

        // Player 1 motion codes
        key_left = 2'b10; key_right = 2'b10; step();
        chk("p1_both_ground", mo(1), 0);
        key_jump = 2'b10; step();
        chk("p1_both_air", mo(1), 3);
        key_jump = 2'b00; key_right = 2'b00; step();
        chk("p1_left", mo(1), 1);
        chk("p0_unaffected", mo(0), 0);
        key_left = 2'b00;
        repeat (2 * JH - 2) step();
        chk("p1_land", ph(1), 0);

        // Pause lands on the edge that takes cnt to 2
        key_jump = 2'b01; step();
        key_jump = 2'b00; key_pause = 1'b1; step();
        chk("pause_on", 32'(paused), 1);
        chk("pause_cnt", cn(0), 2);
        key_pause = 1'b0;
        repeat (10) step();
        chk("pause_hold_cnt", cn(0), 2);
        chk("pause_hold_phase", ph(0), 1);
        key_pause = 1'b1; step();
        chk("pause_off", 32'(paused), 0);
        chk("pause_off_cnt", cn(0), 2);
        key_pause = 1'b0; step();
        chk("resume_cnt", cn(0), 3);

        step();
        key_pause = 1'b1; step();
        key_pause = 1'b0;
        chk("pre_rst_cnt", cn(0), 5);
        chk("pre_rst_paused", 32'(paused), 1);

        // Asynchronous reset mid-cycle, mid-jump, while paused
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_sel", 32'(select_level), 1);
        chk("arst_paused", 32'(paused), 0);
        chk("arst_pjump", 32'(player_jump), 0);
        chk("arst_pstate", 32'(player_state), 0);
        chk("arst_cnt", 32'(jump_cnt), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_cnt", 32'(jump_cnt), 0);
        chk("post_rst_state", 32'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
